// File: rtl/cpu_defs.sv
// Shared writeback-stage definitions: exception codes, CSR indices, payload bit-field layout.
// Pure declarations; no timing or flow-control content.
// Imported by wb_stage and wb_exc_encode.
package cpu_defs;

   localparam logic [5:0] ECODE_INT  = 6'h00;
   localparam logic [5:0] ECODE_ADEF = 6'h08;
   localparam logic [5:0] ECODE_ALE  = 6'h09;
   localparam logic [5:0] ECODE_SYS  = 6'h0B;
   localparam logic [5:0] ECODE_BRK  = 6'h0C;
   localparam logic [5:0] ECODE_INE  = 6'h0D;

   localparam logic [13:0] CSR_CRMD = 14'h000;
   localparam logic [13:0] CSR_ASID = 14'h018;
   localparam logic [13:0] CSR_DMW0 = 14'h180;
   localparam logic [13:0] CSR_DMW1 = 14'h181;

   // exc_rf = {INT,ADEF,ALE,BRK,INE,SYS,ertn}
   localparam int EXC_INT  = 6;
   localparam int EXC_ADEF = 5;
   localparam int EXC_ALE  = 4;
   localparam int EXC_BRK  = 3;
   localparam int EXC_INE  = 2;
   localparam int EXC_SYS  = 1;
   localparam int EXC_ERTN = 0;

   localparam int CSR_RD_BIT   = 79;
   localparam int CSR_WR_BIT   = 78;
   localparam int CSR_NUM_LSB  = 64;
   localparam int CSR_MASK_LSB = 32;
   localparam int CSR_WVAL_LSB = 0;

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [13:0] num;
      logic [31:0] mask;
      logic [31:0] wvalue;
   } csr_rf_t;

   // CSRs whose update changes translation/privilege state seen by younger fetches
   function automatic logic is_refetch_csr(input logic [13:0] num);
      return (num == CSR_CRMD) || (num == CSR_ASID) ||
             (num == CSR_DMW0) || (num == CSR_DMW1);
   endfunction

endpackage

// File: rtl/wb_exc_encode.sv
// Priority encoder INT>ADEF>INE>BRK>SYS>ALE from exception flags to code and bad address.
// Latency: combinational.
// Backpressure: none; outputs forced to 0 when the stage holds no valid instruction.
module wb_exc_encode
   import cpu_defs::*;
(
   input  logic        valid,
   input  logic [6:0]  exc_rf,
   input  logic [31:0] pc,
   input  logic [31:0] fault_vaddr,
   output logic        wb_ex,
   output logic [5:0]  ecode,
   output logic [8:0]  esubcode,
   output logic [31:0] vaddr
);

   always_comb begin
      wb_ex    = valid & (|exc_rf[6:1]);
      ecode    = '0;
      esubcode = '0;
      vaddr    = '0;
      if (valid) begin
         if (exc_rf[EXC_INT]) begin
            ecode = ECODE_INT;
         end else if (exc_rf[EXC_ADEF]) begin
            ecode = ECODE_ADEF;
            vaddr = pc;
         end else if (exc_rf[EXC_INE]) begin
            ecode = ECODE_INE;
         end else if (exc_rf[EXC_BRK]) begin
            ecode = ECODE_BRK;
         end else if (exc_rf[EXC_SYS]) begin
            ecode = ECODE_SYS;
         end else if (exc_rf[EXC_ALE]) begin
            ecode = ECODE_ALE;
            vaddr = fault_vaddr;
         end
      end
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: commits GPR/CSR/TLB effects, raises exception/ertn/refetch flushes, drives trace.
// Latency: 1 cycle capture from mem stage; commit strobes and cancel are combinational from WB regs.
// Backpressure: none (always ready); WB_TRACE_REG_EN registers the debug trace one extra cycle.
module wb_stage
   import cpu_defs::*;
#(
   parameter logic [31:0] PC_RESET = 32'h1c000000,
   parameter int          ECODE_W  = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               mem_to_wb_valid,
   output logic               wb_allowin,
   input  logic [31:0]        mem_pc,
   input  logic               mem_rf_we,
   input  logic [4:0]         mem_rf_waddr,
   input  logic [31:0]        mem_rf_wdata,
   input  logic [6:0]         mem_exc_rf,
   input  logic [79:0]        mem_csr_rf,
   input  logic [2:0]         mem_tlb_rf,
   input  logic [31:0]        mem_fault_vaddr,
   output logic               rf_we,
   output logic [4:0]         rf_waddr,
   output logic [31:0]        rf_wdata,
   output logic [38:0]        wb_fwd,
   output logic [13:0]        csr_num,
   input  logic [31:0]        csr_rvalue,
   output logic               csr_we,
   output logic [31:0]        csr_wmask,
   output logic [31:0]        csr_wvalue,
   output logic               wb_ex,
   output logic [ECODE_W-1:0] wb_ecode,
   output logic [8:0]         wb_esubcode,
   output logic [31:0]        wb_pc,
   output logic [31:0]        wb_vaddr,
   output logic               ertn_flush,
   output logic [2:0]         tlb_op,
   output logic               refetch,
   output logic [31:0]        refetch_pc,
   output logic               cancel_exc_ertn_tlbflush,
   output logic [63:0]        inst_retired,
   output logic [31:0]        debug_wb_pc,
   output logic [3:0]         debug_wb_rf_we,
   output logic [4:0]         debug_wb_rf_wnum,
   output logic [31:0]        debug_wb_rf_wdata
);

   logic        wb_valid;
   logic [31:0] pc_r;
   logic        rf_we_r;
   logic [4:0]  waddr_r;
   logic [31:0] wdata_r;
   logic [6:0]  exc_r;
   csr_rf_t     csr_r;
   logic [2:0]  tlb_r;
   logic [31:0] fvaddr_r;
   logic        commit;
   logic [5:0]  ecode;

   assign wb_allowin = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid <= 1'b0;
         pc_r     <= PC_RESET;
         rf_we_r  <= 1'b0;
         waddr_r  <= '0;
         wdata_r  <= '0;
         exc_r    <= '0;
         csr_r    <= '0;
         tlb_r    <= '0;
         fvaddr_r <= '0;
      end else begin
         // a flush in WB also kills whatever mem hands over this cycle
         wb_valid <= mem_to_wb_valid & ~cancel_exc_ertn_tlbflush;
         if (mem_to_wb_valid) begin
            pc_r     <= mem_pc;
            rf_we_r  <= mem_rf_we;
            waddr_r  <= mem_rf_waddr;
            wdata_r  <= mem_rf_wdata;
            exc_r    <= mem_exc_rf;
            csr_r    <= csr_rf_t'(mem_csr_rf);
            tlb_r    <= mem_tlb_rf;
            fvaddr_r <= mem_fault_vaddr;
         end
      end
   end

   wb_exc_encode u_exc_encode (
      .valid       (wb_valid),
      .exc_rf      (exc_r),
      .pc          (pc_r),
      .fault_vaddr (fvaddr_r),
      .wb_ex       (wb_ex),
      .ecode       (ecode),
      .esubcode    (wb_esubcode),
      .vaddr       (wb_vaddr)
   );

   assign wb_ecode   = ECODE_W'(ecode);
   assign commit     = wb_valid & ~wb_ex;
   assign ertn_flush = wb_valid & exc_r[EXC_ERTN] & ~wb_ex;

   assign rf_we    = commit & rf_we_r;
   assign rf_waddr = waddr_r;
   assign rf_wdata = csr_r.rd ? csr_rvalue : wdata_r;
   assign wb_fwd   = {wb_valid, rf_we, rf_waddr, rf_wdata};

   assign csr_num    = csr_r.num;
   assign csr_we     = commit & csr_r.wr;
   assign csr_wmask  = csr_r.mask;
   assign csr_wvalue = csr_r.wvalue;

   assign tlb_op     = {3{commit}} & tlb_r;
   assign refetch    = commit & ((|tlb_r) | (csr_r.wr & is_refetch_csr(csr_r.num)));
   assign wb_pc      = pc_r;
   assign refetch_pc = wb_valid ? pc_r + 32'd4 : 32'd0;

   assign cancel_exc_ertn_tlbflush = wb_ex | ertn_flush | refetch;

   always_ff @(posedge clk) begin
      if (reset) begin
         inst_retired <= '0;
      end else if (commit) begin
         inst_retired <= inst_retired + 64'd1;
      end
   end

`ifdef WB_TRACE_REG_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         debug_wb_pc       <= '0;
         debug_wb_rf_we    <= '0;
         debug_wb_rf_wnum  <= '0;
         debug_wb_rf_wdata <= '0;
      end else begin
         debug_wb_rf_we <= {4{rf_we}};
         if (wb_valid) begin
            debug_wb_pc       <= wb_pc;
            debug_wb_rf_wnum  <= rf_waddr;
            debug_wb_rf_wdata <= rf_wdata;
         end
      end
   end
`else
   assign debug_wb_pc       = wb_pc;
   assign debug_wb_rf_we    = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (default build, combinational trace).
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_to_wb_valid;
   logic        wb_allowin;
   logic [31:0] mem_pc;
   logic        mem_rf_we;
   logic [4:0]  mem_rf_waddr;
   logic [31:0] mem_rf_wdata;
   logic [6:0]  mem_exc_rf;
   logic [79:0] mem_csr_rf;
   logic [2:0]  mem_tlb_rf;
   logic [31:0] mem_fault_vaddr;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [38:0] wb_fwd;
   logic [13:0] csr_num;
   logic [31:0] csr_rvalue;
   logic        csr_we;
   logic [31:0] csr_wmask;
   logic [31:0] csr_wvalue;
   logic        wb_ex;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [31:0] wb_pc;
   logic [31:0] wb_vaddr;
   logic        ertn_flush;
   logic [2:0]  tlb_op;
   logic        refetch;
   logic [31:0] refetch_pc;
   logic        cancel;
   logic [63:0] inst_retired;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_we;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .reset(reset), .mem_to_wb_valid(mem_to_wb_valid), .wb_allowin(wb_allowin),
      .mem_pc(mem_pc), .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
      .mem_rf_wdata(mem_rf_wdata), .mem_exc_rf(mem_exc_rf), .mem_csr_rf(mem_csr_rf),
      .mem_tlb_rf(mem_tlb_rf), .mem_fault_vaddr(mem_fault_vaddr),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_fwd(wb_fwd),
      .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we), .csr_wmask(csr_wmask),
      .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
      .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .tlb_op(tlb_op),
      .refetch(refetch), .refetch_pc(refetch_pc), .cancel_exc_ertn_tlbflush(cancel),
      .inst_retired(inst_retired), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_mem(input logic v, input logic [31:0] pc, input logic we,
                          input logic [4:0] wa, input logic [31:0] wd, input logic [6:0] exc,
                          input logic [79:0] csr, input logic [2:0] tlb, input logic [31:0] fv);
      mem_to_wb_valid = v;
      mem_pc          = pc;
      mem_rf_we       = we;
      mem_rf_waddr    = wa;
      mem_rf_wdata    = wd;
      mem_exc_rf      = exc;
      mem_csr_rf      = csr;
      mem_tlb_rf      = tlb;
      mem_fault_vaddr = fv;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mem_to_wb_valid = 1'b0;
      tick();
   endtask

   function automatic logic [79:0] csr_word(input logic rd, input logic wr, input logic [13:0] num,
                                            input logic [31:0] mask, input logic [31:0] val);
      return {rd, wr, num, mask, val};
   endfunction

   initial begin
      reset      = 1'b1;
      csr_rvalue = 32'h0;
      set_mem(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();

      check("rst_allowin",   64'(wb_allowin), 64'h1);
      check("rst_rf_we",     64'(rf_we), 64'h0);
      check("rst_wb_ex",     64'(wb_ex), 64'h0);
      check("rst_cancel",    64'(cancel), 64'h0);
      check("rst_wb_pc",     64'(wb_pc), 64'h1c000000);
      check("rst_retired",   inst_retired, 64'h0);
      check("rst_csr_we",    64'(csr_we), 64'h0);
      check("rst_tlb_op",    64'(tlb_op), 64'h0);
      check("rst_refetchpc", 64'(refetch_pc), 64'h0);
      check("rst_fwd",       64'(wb_fwd), 64'h0);
      reset = 1'b0;

      // plain GPR write
      set_mem(1, 32'h1c000100, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
      tick();
      check("t1_rf_we",    64'(rf_we), 64'h1);
      check("t1_waddr",    64'(rf_waddr), 64'h5);
      check("t1_wdata",    64'(rf_wdata), 64'hDEADBEEF);
      check("t1_dbg_we",   64'(debug_wb_rf_we), 64'hF);
      check("t1_dbg_pc",   64'(debug_wb_pc), 64'h1c000100);
      check("t1_fwd",      64'(wb_fwd), {25'h0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF});
      check("t1_cancel",   64'(cancel), 64'h0);
      idle();
      check("t1_retired",  inst_retired, 64'h1);
      check("t1_idle_we",  64'(rf_we), 64'h0);

      // SYS exception; younger instruction arriving meanwhile is killed
      set_mem(1, 32'h1c000200, 1, 5'd3, 32'h55, 7'b0000010, 0, 0, 0);
      tick();
      check("t2_wb_ex",    64'(wb_ex), 64'h1);
      check("t2_ecode",    64'(wb_ecode), 64'h0B);
      check("t2_esub",     64'(wb_esubcode), 64'h0);
      check("t2_rf_we",    64'(rf_we), 64'h0);
      check("t2_cancel",   64'(cancel), 64'h1);
      check("t2_ertn",     64'(ertn_flush), 64'h0);
      set_mem(1, 32'h1c000204, 1, 5'd4, 32'h66, 0, 0, 0, 0);
      tick();
      check("t2_killed",   64'(wb_fwd[38]), 64'h0);
      check("t2_kill_we",  64'(rf_we), 64'h0);
      check("t2_kill_cn",  64'(cancel), 64'h0);
      idle();
      check("t2_retired",  inst_retired, 64'h1);

      // INT beats ALE, then ALE alone, then ADEF
      set_mem(1, 32'h1c000400, 0, 0, 0, 7'b1010000, 0, 0, 32'h1003);
      tick();
      check("t3_int_ex",   64'(wb_ex), 64'h1);
      check("t3_int_code", 64'(wb_ecode), 64'h00);
      check("t3_int_va",   64'(wb_vaddr), 64'h0);
      idle();
      set_mem(1, 32'h1c000404, 0, 0, 0, 7'b0010000, 0, 0, 32'h1003);
      tick();
      check("t3_ale_code", 64'(wb_ecode), 64'h09);
      check("t3_ale_va",   64'(wb_vaddr), 64'h1003);
      idle();
      set_mem(1, 32'h1c000501, 0, 0, 0, 7'b0101000, 0, 0, 32'h77);
      tick();
      check("t3_adef_code", 64'(wb_ecode), 64'h08);
      check("t3_adef_va",   64'(wb_vaddr), 64'h1c000501);
      idle();
      check("t3_idle_va",  64'(wb_vaddr), 64'h0);

      // CSR write to ASID triggers refetch; same write elsewhere does not
      set_mem(1, 32'h1c000300, 0, 0, 0, 0, csr_word(0, 1, 14'h18, 32'hFFFF_FFFF, 32'h1), 0, 0);
      tick();
      check("t4_csr_we",   64'(csr_we), 64'h1);
      check("t4_csr_num",  64'(csr_num), 64'h18);
      check("t4_wvalue",   64'(csr_wvalue), 64'h1);
      check("t4_wmask",    64'(csr_wmask), 64'hFFFFFFFF);
      check("t4_refetch",  64'(refetch), 64'h1);
      check("t4_rf_pc",    64'(refetch_pc), 64'h1c000304);
      check("t4_cancel",   64'(cancel), 64'h1);
      idle();
      set_mem(1, 32'h1c000308, 0, 0, 0, 0, csr_word(0, 1, 14'h5, 32'hFFFF_FFFF, 32'h1), 0, 0);
      tick();
      check("t4b_csr_we",  64'(csr_we), 64'h1);
      check("t4b_refetch", 64'(refetch), 64'h0);
      check("t4b_cancel",  64'(cancel), 64'h0);
      idle();
      check("t4_retired",  inst_retired, 64'h3);

      // CSR read into GPR, then TLB write
      csr_rvalue = 32'h12345678;
      set_mem(1, 32'h1c000600, 1, 5'd7, 32'hAAAA, 0, csr_word(1, 0, 14'h5, 0, 0), 0, 0);
      tick();
      check("t5_rd_we",    64'(rf_we), 64'h1);
      check("t5_rd_addr",  64'(rf_waddr), 64'h7);
      check("t5_rd_data",  64'(rf_wdata), 64'h12345678);
      check("t5_rd_csrwe", 64'(csr_we), 64'h0);
      idle();
      set_mem(1, 32'h1c000700, 0, 0, 0, 0, 0, 3'b010, 0);
      tick();
      check("t5_tlb_op",   64'(tlb_op), 64'h2);
      check("t5_tlb_cn",   64'(cancel), 64'h1);
      check("t5_tlb_rfch", 64'(refetch), 64'h1);
      idle();

      // exception beats ertn; CSR write suppressed; then ertn alone
      set_mem(1, 32'h1c000800, 0, 0, 0, 7'b0000011, csr_word(0, 1, 14'h18, 32'hF, 32'h3), 0, 0);
      tick();
      check("t6_ex",       64'(wb_ex), 64'h1);
      check("t6_ertn",     64'(ertn_flush), 64'h0);
      check("t6_csr_we",   64'(csr_we), 64'h0);
      check("t6_refetch",  64'(refetch), 64'h0);
      idle();
      set_mem(1, 32'h1c000900, 0, 0, 0, 7'b0000001, 0, 0, 0);
      tick();
      check("t6b_ertn",    64'(ertn_flush), 64'h1);
      check("t6b_ex",      64'(wb_ex), 64'h0);
      check("t6b_cancel",  64'(cancel), 64'h1);
      idle();
      check("t6_retired",  inst_retired, 64'h6);

      // reset arriving while a TLB flush is cancelling
      set_mem(1, 32'h1c000a00, 1, 5'd9, 32'h99, 0, 0, 3'b001, 0);
      tick();
      check("t7_pre_cn",   64'(cancel), 64'h1);
      reset = 1'b1;
      set_mem(1, 32'h1c000a04, 1, 5'd10, 32'h9A, 0, csr_word(0, 1, 14'h0, 32'h1, 32'h1), 3'b100, 0);
      tick();
      check("t7_rf_we",    64'(rf_we), 64'h0);
      check("t7_csr_we",   64'(csr_we), 64'h0);
      check("t7_tlb_op",   64'(tlb_op), 64'h0);
      check("t7_cancel",   64'(cancel), 64'h0);
      check("t7_wb_pc",    64'(wb_pc), 64'h1c000000);
      check("t7_retired",  inst_retired, 64'h0);
      reset = 1'b0;
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
